flow_arbiter: RTL
=================

// Module: flow_arbiter
// PURPOSE
//  Round-robin arbiter that shares the 20-bit word path among N_REQ requesters.
//  Drives the 5-bit select of the MUX (requester -> shared path) and of the DEMUX (shared path -> requester).
//  Grants one requester at a time for a bounded burst, then inserts one idle gap cycle so both selects settle before the next grant.
// PARAMETERS
//  N_REQ      32  number of requesters; must equal 2**SEL_W
//  SEL_W      5   select width; matches MUX/DEMUX sel
//  MAX_BURST  8   max consecutive granted beats per grant, 1..2**CNT_W-1
//  CNT_W      4   beat counter width
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        synchronous reset, active-high
//  req       in   N_REQ    request per requester; level, held while the requester wants the path
//  gnt       out  N_REQ    one-hot grant, registered; all-zero when no owner
//  sel       out  SEL_W    index of the current or last owner; wired to MUX/DEMUX sel
//  busy      out  1        1 while in GRANT
//  beat_cnt  out  CNT_W    beats consumed in the current grant
//  lock      in   1        burst-limit override; present only with FLOW_ARB_LOCK_EN
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, gnt=0, sel=0, busy=0, beat_cnt=0, rr_ptr=0.
//  rst has priority over every other event. Mid-grant, gnt drops on the next edge with no gap cycle.
//  rr_ptr: the search starts at rr_ptr and wraps modulo N_REQ. Index 31 wraps to 0.
//  States:
//   IDLE : if req!=0, pick the first set bit at or after rr_ptr (winner w).
//          Next edge: gnt=1<<w, sel=w, busy=1, beat_cnt=1, go to GRANT.
//          Latency is 1 cycle from req sampled to gnt visible. If req==0, stay in IDLE.
//   GRANT: each cycle with req[sel]=1 is one beat.
//          Release when req[sel]=0 or beat_cnt==MAX_BURST.
//          On release: next edge gnt=0, busy=0, beat_cnt=0, rr_ptr=(sel+1) mod N_REQ, go to GAP.
//          Otherwise beat_cnt increments.
//   GAP  : exactly 1 cycle with gnt=0; sel holds its value. Then go to IDLE.
//  Effective throughput: a new owner is granted at the earliest 2 cycles after release.
//  Requests from non-owners during GRANT/GAP are ignored until IDLE; no request is lost because req is level.
//  Owner drops req and re-asserts during GAP: it sits behind rr_ptr, so every other active requester is served first.
//  Single requester re-requesting: gnt pattern is MAX_BURST on, 1 gap, 1 arbitration cycle, repeat.
//  req bits other than the owner's changing during GRANT has no effect on gnt or sel.
//  gnt is always one-hot or zero; gnt[sel]==busy at all times.
//  beat_cnt never exceeds MAX_BURST.
// CONFIGURATION
//  FLOW_ARB_LOCK_EN defined:
//   - adds the lock input.
//   - In GRANT with lock=1, the MAX_BURST limit is suppressed and beat_cnt saturates at MAX_BURST.
//   - Release happens only on req[sel]=0.
//   - lock is ignored in IDLE/GAP.
//  FLOW_ARB_LOCK_EN undefined:
//   - no lock port.
//   - the burst limit always applies.
// TESTING
//  1 Reset: rst=1 for 2 cycles with req=32'hFFFFFFFF -> gnt=0, sel=0, busy=0, beat_cnt=0 throughout.
//  2 Single grant: req=32'h00000020 held 3 cycles then dropped -> gnt=32'h20 one cycle after req, sel=5;
//    beat_cnt 1,2,3; gnt=0 after; 1 gap cycle.
//  3 Round-robin: req=32'h80000003 held constantly, MAX_BURST=8 -> owners 0,1,31,0 in order;
//    each grant 8 beats; gnt=0 for 2 cycles between grants.
//  4 Wrap: after owner 31 releases, req=32'h80000001 -> next owner is 0 (rr_ptr wraps to 0).
//  5 Reset mid-grant: owner 7 at beat_cnt=4, rst=1 -> next edge gnt=0, sel=0, state IDLE;
//    after rst=0 with req[7]=1, req[3]=1 -> winner 3.
//  6 Lock (FLOW_ARB_LOCK_EN): lock=1, req[2] held 12 cycles -> single grant of 12 beats, beat_cnt saturates at 8;
//    same stimulus without the macro -> release after 8 beats.

Source files
------------

// File: rtl/flow_arbiter.sv
// Round-robin arbiter for the shared 20-bit word path: bounded bursts, one idle gap between grants.
// Optional FLOW_ARB_LOCK_EN adds lock_i, which lets the owner hold the path past MAX_BURST.
module flow_arbiter #(
    parameter int unsigned N_REQ     = 32,
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
`ifdef FLOW_ARB_LOCK_EN
    input  logic             lock_i,
`endif
    output logic [N_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] beat_cnt_o
);

    localparam logic [CNT_W-1:0] MaxBurst = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] idx;
    logic             found;
    logic             lock_active;
    logic             at_limit;
    logic             release_grant;

`ifdef FLOW_ARB_LOCK_EN
    assign lock_active = lock_i;
`else
    assign lock_active = 1'b0;
`endif

    // First requester at or after rr_ptr; index arithmetic wraps because N_REQ == 2**SEL_W.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        idx    = rr_ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = rr_ptr_q + SEL_W'(i);
            if (!found && req_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign at_limit      = (beat_q == MaxBurst);
    assign release_grant = !req_i[sel_q] || (at_limit && !lock_active);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        gnt_d    = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    sel_d   = winner;
                    beat_d  = CNT_W'(1);
                    gnt_d   = N_REQ'(1) << winner;
                end
            end
            StGrant: begin
                if (release_grant) begin
                    state_d  = StGap;
                    gnt_d    = '0;
                    beat_d   = '0;
                    rr_ptr_d = sel_q + SEL_W'(1);
                end else if (!at_limit) begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q    <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            gnt_q    <= '0;
        end else begin
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            gnt_q    <= gnt_d;
        end
    end

    always_comb begin
        busy_o     = (state_q == StGrant);
        gnt_o      = gnt_q;
        sel_o      = sel_q;
        beat_cnt_o = beat_q;
    end

endmodule
